// File: rtl/jay_pkg.sv
// Shared types and instruction field positions for the JAY sequential core:
// opcode and FSM state enums, 9-bit instruction field slices.
package jay_pkg;

  typedef enum logic [2:0] {ADD, XOR, AND, RLC, ADDI, LD, ST, BR} op_t;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  localparam int OP_HI    = 8;
  localparam int OP_LO    = 6;
  localparam int A_HI     = 5;
  localparam int A_LO     = 3;
  localparam int B_HI     = 2;
  localparam int B_LO     = 0;
  localparam int OFS_HI   = 4;
  localparam int OFS_LO   = 0;
  localparam int COND_BIT = 5;

  function automatic op_t get_op(input logic [8:0] ins);
    return op_t'(ins[OP_HI:OP_LO]);
  endfunction

endpackage

// File: rtl/jay_alu.sv
// JAY datapath ALU: ADD/XOR/AND/RLC/ADDI with carry, zero and parity outputs.
// Purely combinational; no handshake, result valid in the same cycle.
module jay_alu
  import jay_pkg::*;
#(
  parameter int W = 8
) (
  input  op_t          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sc_i,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         zero,
  output logic         parity
);

  logic         cin;
  logic [W:0]   sum;

  always_comb begin
    // Only ADD folds the carry in; ADDI shares the adder without it.
    cin  = sc_i & (op == ADD);
    sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    rslt = a;
    sc_o = sc_i;
    case (op)
      ADD, ADDI: begin
        rslt = sum[W-1:0];
        sc_o = sum[W];
      end
      XOR: rslt = a ^ b;
      AND: rslt = a & b;
      RLC: begin
        rslt = {a[W-2:0], sc_i};
        sc_o = a[W-1];
      end
      default: ;
    endcase
  end

  assign zero   = (rslt == '0);
  assign parity = ^rslt;

endmodule

// File: rtl/jay_seq_core.sv
// Multi-cycle JAY core: FETCH/EXEC/MEM FSM, 2 cycles per ALU/ST/BR, 3 per LD.
// req/done start handshake; JAY_PARITY_EN adds a parity flag for BR bit 5.
module jay_seq_core
  import jay_pkg::*;
#(
  parameter int W         = 8,
  parameter int D         = 12,
  parameter int HALT_ADDR = 296
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req,
  output logic         done,
  output logic [D-1:0] imem_addr,
  input  logic [8:0]   imem_data,
  output logic [W-1:0] dmem_addr,
  output logic [W-1:0] dmem_wdata,
  output logic         dmem_we,
  input  logic [W-1:0] dmem_rdata
);

  localparam logic [D-1:0] HALT_PC = D'(HALT_ADDR);

  state_t       state;
  logic [D-1:0] pc;
  logic [W-1:0] rf [8];
  logic         sc;
  logic         zf;
  logic [2:0]   ld_dst;
`ifdef JAY_PARITY_EN
  logic         pf;
`endif

  op_t          op;
  logic [2:0]   ra;
  logic [2:0]   rb;
  logic [W-1:0] rf_a;
  logic [W-1:0] rf_b;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_rslt;
  logic         alu_sc;
  logic         alu_zero;
  logic         alu_par;
  logic         br_take;
  logic [D-1:0] br_ofs;

  // The instruction word is only meaningful during EXEC, one cycle after FETCH.
  assign op     = get_op(imem_data);
  assign ra     = imem_data[A_HI:A_LO];
  assign rb     = imem_data[B_HI:B_LO];
  assign rf_a   = rf[ra];
  assign rf_b   = rf[rb];
  assign alu_b  = (op == ADDI) ? {{(W-3){1'b0}}, rb} : rf_b;
  assign br_ofs = {{(D-5){imem_data[OFS_HI]}}, imem_data[OFS_HI:OFS_LO]};

`ifdef JAY_PARITY_EN
  assign br_take = imem_data[COND_BIT] ? pf : zf;
`else
  logic par_unused;
  assign par_unused = alu_par;
  assign br_take    = imem_data[COND_BIT] | zf;
`endif

  jay_alu #(.W(W)) u_alu (
    .op     (op),
    .a      (rf_a),
    .b      (alu_b),
    .sc_i   (sc),
    .rslt   (alu_rslt),
    .sc_o   (alu_sc),
    .zero   (alu_zero),
    .parity (alu_par)
  );

  // Memory strobes decode straight from state so reset drops them at once.
  assign imem_addr  = pc;
  assign dmem_we    = (state == EXEC) && (op == ST);
  assign dmem_addr  = (state == EXEC) ? rf_b : '0;
  assign dmem_wdata = dmem_we ? rf_a : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= '0;
      sc     <= 1'b0;
      zf     <= 1'b0;
      ld_dst <= '0;
      done   <= 1'b0;
`ifdef JAY_PARITY_EN
      pf     <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            pc    <= '0;
            state <= FETCH;
          end
        end
        FETCH: begin
          state <= (pc == HALT_PC) ? HALT : EXEC;
          done  <= (pc == HALT_PC);
        end
        EXEC: begin
          state <= FETCH;
          pc    <= pc + 1'b1;
          case (op)
            ADD, XOR, AND, RLC, ADDI: begin
              rf[ra] <= alu_rslt;
              sc     <= alu_sc;
              zf     <= alu_zero;
`ifdef JAY_PARITY_EN
              pf     <= alu_par;
`endif
            end
            LD: begin
              ld_dst <= ra;
              pc     <= pc;
              state  <= MEM;
            end
            BR: if (br_take) pc <= pc + br_ofs;
            default: ;
          endcase
        end
        MEM: begin
          rf[ld_dst] <= dmem_rdata;
          pc         <= pc + 1'b1;
          state      <= FETCH;
        end
        HALT: begin
          if (!req) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jay_seq_core.sv
// Scoreboarded bench for jay_seq_core: small programs in a synchronous imem,
// expected stores queued up front and matched against each dmem_we cycle.
module tb_jay_seq_core;

  localparam int W    = 8;
  localparam int D    = 12;
  localparam int HALT = 16;

  localparam logic [2:0] O_ADD  = 3'd0;
  localparam logic [2:0] O_RLC  = 3'd3;
  localparam logic [2:0] O_ADDI = 3'd4;
  localparam logic [2:0] O_LD   = 3'd5;
  localparam logic [2:0] O_ST   = 3'd6;
  localparam logic [8:0] PAD    = 9'b110_111_111;

  logic         clk = 1'b0;
  logic         reset;
  logic         req;
  logic         done;
  logic [D-1:0] imem_addr;
  logic [8:0]   imem_data;
  logic [W-1:0] dmem_addr;
  logic [W-1:0] dmem_wdata;
  logic         dmem_we;
  logic [W-1:0] dmem_rdata;

  logic [8:0]   imem [256];
  logic [W-1:0] dmem [256];
  logic [15:0]  sb_q [$];
  int           n_run  = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  jay_seq_core #(.W(W), .D(D), .HALT_ADDR(HALT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_we    (dmem_we),
    .dmem_rdata (dmem_rdata)
  );

  always @(posedge clk) begin
    imem_data  <= imem[imem_addr[7:0]];
    dmem_rdata <= dmem[dmem_addr];
    if (dmem_we === 1'b1) dmem[dmem_addr] = dmem_wdata;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && dmem_we === 1'b1) begin
      if (sb_q.size() == 0)
        check_eq("st_extra", 32'(sb_q.size()), 1);
      else
        check_eq("st", 32'({dmem_addr, dmem_wdata}), 32'(sb_q.pop_front()));
    end
  end

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b};
  endfunction

  function automatic logic [8:0] br_i(input logic c, input int ofs);
    logic [31:0] t;
    t = ofs;
    return {3'd7, c, t[4:0]};
  endfunction

  task automatic push_st(input logic [7:0] a, input logic [7:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic load_pad();
    for (int i = 0; i < 256; i++) begin
      imem[i] = PAD;
      dmem[i] = '0;
    end
  endtask

  task automatic do_reset();
    req   = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_prog(input string tag, input int exp_lat, input int hold);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    @(negedge clk);
    req = 1'b1;
    while (!seen && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) check_eq({tag, "_pc0"}, 32'(imem_addr), 0);
      seen = (done === 1'b1);
    end
    check_eq({tag, "_lat"}, cyc, exp_lat);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      check_eq({tag, "_hold"}, 32'(done), 1);
    end
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, "_drop"}, 32'(done), 0);
    check_eq({tag, "_left"}, 32'(sb_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req   = 1'b0;
    load_pad();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_we", 32'(dmem_we), 0);
    check_eq("rst_iaddr", 32'(imem_addr), 0);
    check_eq("rst_daddr", 32'(dmem_addr), 0);
    check_eq("rst_wdata", 32'(dmem_wdata), 0);
    reset = 1'b1;

    // ADDI chain, single store, branch straight onto the halt address.
    imem[0] = enc(O_ADDI, 1, 5);
    imem[1] = enc(O_ADDI, 1, 3);
    imem[2] = enc(O_ST, 1, 0);
    imem[3] = br_i(1'b1, 13);
    push_st(8'h00, 8'h08);
    run_prog("t1", 10, 0);

    // ADD with carry-out and zero, zf branch, RLC pulls the carry in.
    do_reset();
    load_pad();
    dmem[0]  = 8'hFF;
    imem[0]  = enc(O_LD, 1, 0);
    imem[1]  = enc(O_ADDI, 2, 1);
    imem[2]  = enc(O_ADD, 1, 2);
    imem[3]  = enc(O_ST, 1, 0);
    imem[4]  = br_i(1'b0, 2);
    imem[5]  = enc(O_ST, 2, 2);
    imem[6]  = enc(O_RLC, 2, 0);
    imem[7]  = enc(O_ST, 2, 0);
    imem[8]  = enc(O_ADD, 3, 0);
    imem[9]  = enc(O_ST, 3, 0);
    imem[10] = br_i(1'b1, 6);
    push_st(8'h00, 8'h00);
    push_st(8'h00, 8'h03);
    push_st(8'h00, 8'h00);
    run_prog("t2", 23, 0);

    // Store then load through the same address.
    do_reset();
    load_pad();
    dmem[1] = 8'h10;
    dmem[2] = 8'hA5;
    imem[0] = enc(O_ADDI, 7, 1);
    imem[1] = enc(O_LD, 3, 7);
    imem[2] = enc(O_ADDI, 7, 1);
    imem[3] = enc(O_LD, 4, 7);
    imem[4] = enc(O_ST, 4, 3);
    imem[5] = enc(O_LD, 5, 3);
    imem[6] = enc(O_ST, 5, 0);
    imem[7] = br_i(1'b1, 9);
    push_st(8'h10, 8'hA5);
    push_st(8'h00, 8'hA5);
    run_prog("t3", 21, 0);

    // Backward zf branch from pc 10 to 8 once, then falls through to 11.
    do_reset();
    load_pad();
    dmem[0]  = 8'h80;
    imem[0]  = enc(O_LD, 1, 0);
    imem[1]  = br_i(1'b1, 7);
    imem[8]  = enc(O_ST, 1, 0);
    imem[9]  = enc(O_RLC, 1, 0);
    imem[10] = br_i(1'b0, -2);
    imem[11] = enc(O_ST, 1, 0);
    imem[12] = br_i(1'b1, 4);
    push_st(8'h00, 8'h80);
    push_st(8'h00, 8'h00);
    push_st(8'h00, 8'h01);
    run_prog("t4", 23, 0);

    // Bit-5 branches after odd (0x07) and even (0x0C) parity results.
    do_reset();
    load_pad();
    imem[0] = enc(O_ADDI, 2, 7);
    imem[1] = br_i(1'b1, 2);
    imem[2] = enc(O_ST, 2, 2);
    imem[3] = enc(O_ST, 2, 0);
    imem[4] = enc(O_ADDI, 2, 5);
    imem[5] = br_i(1'b1, 2);
    imem[6] = enc(O_ST, 2, 2);
    imem[7] = enc(O_ADDI, 2, 4);
    imem[8] = br_i(1'b1, 8);
    push_st(8'h00, 8'h07);
`ifdef JAY_PARITY_EN
    push_st(8'h0C, 8'h0C);
    run_prog("t4p", 18, 0);
`else
    run_prog("t4p", 16, 0);
`endif

    // Reset lands in the MEM cycle of a load.
    do_reset();
    load_pad();
    dmem[0] = 8'h55;
    imem[0] = enc(O_ADDI, 5, 3);
    imem[1] = enc(O_LD, 5, 0);
    imem[2] = enc(O_ST, 5, 0);
    imem[3] = br_i(1'b1, 13);
    @(negedge clk);
    req = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("t5_mem_pc", 32'(imem_addr), 1);
    reset = 1'b0;
    req   = 1'b0;
    #1;
    check_eq("t5_done", 32'(done), 0);
    check_eq("t5_we", 32'(dmem_we), 0);
    check_eq("t5_iaddr", 32'(imem_addr), 0);
    check_eq("t5_daddr", 32'(dmem_addr), 0);
    check_eq("t5_wdata", 32'(dmem_wdata), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("t5_idle_pc", 32'(imem_addr), 0);
    check_eq("t5_idle_done", 32'(done), 0);
    imem[0] = enc(O_ST, 5, 0);
    imem[1] = br_i(1'b1, 15);
    push_st(8'h00, 8'h00);
    run_prog("t5b", 6, 0);

    // req held through HALT, then a rerun on retained registers.
    do_reset();
    load_pad();
    imem[0] = enc(O_ADDI, 1, 1);
    imem[1] = enc(O_ST, 1, 0);
    imem[2] = br_i(1'b1, 14);
    push_st(8'h00, 8'h01);
    run_prog("t6a", 8, 3);
    @(posedge clk);
    #1;
    check_eq("t6_idle_pc", 32'(imem_addr), HALT);
    push_st(8'h00, 8'h02);
    run_prog("t6b", 8, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/jay_seq_core.md
# jay_seq_core

Parametrised multi-cycle successor to the single-cycle JAY processor top level. It runs the 9-bit JAY instruction set through a FETCH/EXEC/MEM state machine. Program start and completion use a `req`/`done` handshake, and instruction and data memories are external synchronous-read ports. Data width, PC width and halt address are parameters, so the core can be reused across workloads without editing the RTL.

## Interface
- `W`, 8: data and register width; must be at least 4.
- `D`, 12: program counter width.
- `HALT_ADDR`, 296: PC value that ends a program.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  start request; sampled in IDLE.
- `done`  out  1  program complete; high only in HALT.
- `imem_addr`  out  D  instruction address; equals `pc`.
- `imem_data`  in  9  instruction; valid one cycle after `imem_addr`.
- `dmem_addr`  out  W  data address.
- `dmem_wdata`  out  W  store data.
- `dmem_we`  out  1  store strobe; one cycle per store.
- `dmem_rdata`  in  W  load data; valid one cycle after `dmem_addr`.

## Operation
**Machine state**
- 8 registers `r0`–`r7` of W bits, a carry bit `sc`, a zero flag `zf`, and `pc` of D bits.

**Instruction fields**
- `op` = bits [8:6], `a` = bits [5:3], `b` = bits [2:0]. `a` and `b` are register indices unless stated otherwise.

**Opcodes**
- 0 ADD: r[a] ← r[a] + r[b] + sc. sc ← carry out of bit W-1.
- 1 XOR: r[a] ← r[a] ^ r[b].
- 2 AND: r[a] ← r[a] & r[b].
- 3 RLC: r[a] ← {r[a][W-2:0], sc}. sc ← old r[a][W-1].
- 4 ADDI: r[a] ← r[a] + zero-extended b. sc ← carry.
- 5 LD: r[a] ← mem[r[b]].
- 6 ST: mem[r[b]] ← r[a].
- 7 BR: offset = sign-extended bits [4:0]. Condition select is bit 5 (see Configuration). Taken: pc ← pc + offset. Not taken: pc ← pc + 1.

**Flag rules**
- Opcodes 0–4 update `zf` from their W-bit result (zf = 1 when the result is zero).
- Opcodes 1 and 2 leave `sc` unchanged.
- LD, ST and BR leave both flags unchanged.

**State machine**
- IDLE: when `req` = 1, set pc ← 0 and go to FETCH.
- FETCH: if pc == HALT_ADDR, go to HALT. Otherwise drive `imem_addr` and go to EXEC.
- EXEC: execute the instruction.
  - LD drives `dmem_addr` and goes to MEM.
  - All other opcodes write back, update pc, and go to FETCH.
- MEM: write `dmem_rdata` into r[a], set pc ← pc + 1, go to FETCH.
- HALT: `done` = 1. When `req` = 0, go to IDLE.

**Arithmetic and boundaries**
- All arithmetic is modulo 2^W. The PC wraps modulo 2^D.
- A branch whose target equals HALT_ADDR halts on the next FETCH.
- `req` is ignored outside IDLE and HALT. A still-high `req` in HALT holds `done` = 1.
- Registers and memory keep their contents across IDLE, so a second `req` reruns the program from pc 0 on the retained state.

## Timing
- Reset values: state = IDLE, pc = 0, all registers = 0, sc = 0, zf = 0.
- Outputs during reset: `done` = 0, `dmem_we` = 0, `imem_addr` = 0, `dmem_addr` = 0, `dmem_wdata` = 0.
- Cycles per instruction: 2 for ALU, ST and BR; 3 for LD.
- From the `req` sample in IDLE, the first instruction's EXEC occurs 2 cycles later.
- `dmem_we` is asserted for exactly the EXEC cycle of a ST, with `dmem_addr` = r[b] and `dmem_wdata` = r[a].
- `done` rises one cycle after the FETCH that sees HALT_ADDR.
- Reset asserted mid-instruction aborts it immediately. There is no partial write-back and `dmem_we` drops asynchronously.

## Configuration
- Macro: `JAY_PARITY_EN`.
- Defined:
  - Adds a parity flag `pf`, reset to 0, updated by opcodes 0–4 as the XOR-reduction of the result.
  - BR with bit 5 = 0 branches if `zf` = 1; bit 5 = 1 branches if `pf` = 1.
- Undefined:
  - No `pf` register exists.
  - BR with bit 5 = 0 branches if `zf` = 1; bit 5 = 1 is an unconditional branch.

## Structure
- Package `jay_pkg` holds:
  - the opcode enum `op_t` (ADD, XOR, AND, RLC, ADDI, LD, ST, BR);
  - the state enum `state_t` (IDLE, FETCH, EXEC, MEM, HALT);
  - field-slice localparams for `op`, `a`, `b` and the offset.
- Sub-module `jay_alu`, parametrised by W: combinational.
  - Inputs: `op`, A, B/immediate, `sc_i`.
  - Outputs: `rslt`, `sc_o`, zero, parity.
- The register file, flags and FSM stay in `jay_seq_core`.

## Test plan
- Reset, then `req` pulse with program `ADDI r1,5; ADDI r1,3` and HALT_ADDR = 2. Expect r1 = 8, `done` high 6 cycles after `req`, `dmem_we` never asserted.
- W = 8, r1 = 0xFF, r2 = 0x01, sc = 0, run ADD r1,r2. Expect r1 = 0x00, sc = 1, zf = 1. A following RLC r2 gives r2 = 0x03, sc = 0.
- r3 = 0x10, r4 = 0xA5, run ST r4,r3 then LD r5,r3. Expect `dmem_we` for exactly one cycle at address 0x10 with data 0xA5. Expect r5 = 0xA5, and the LD takes 3 cycles.
- zf = 1, BR bit5 = 0 with offset -2 at pc 10: expect pc = 8. With zf = 0, expect pc = 11. With `JAY_PARITY_EN` defined, result 0x07 then BR bit5 = 1: taken.
- Assert reset during the MEM cycle of an LD. Expect the destination register unchanged, all outputs at reset values, and state IDLE.
- Hold `req` high through HALT: `done` stays 1. Drop `req`: `done` falls and state is IDLE next cycle. A new `req` restarts from pc 0.
